// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite response codes and regfile FSM state encodings.
// Ports: none (package).
// Imported by the regfile slave top and its address decoder.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_COLLECT = 2'b00,
        W_DELAY   = 2'b01,
        W_RESP    = 2'b10
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'b00,
        R_DELAY = 2'b01,
        R_RESP  = 2'b10
    } r_state_e;

    // Widest supported response delay, sized to a 4-bit countdown.
    localparam int MAX_RESP_LATENCY = 15;

endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite bundle between one crossbar master port and a peripheral.
// Ports: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//        B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready), R (rdata/rresp/rvalid/rready).
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_regfile_decode.sv
// axi_lite_regfile_decode: byte address -> {hit, register index, read-only flag}.
// Ports: addr (in), hit (out), idx (out), ro (out).
// Purely combinational; no latency, no handshake.
module axi_lite_regfile_decode
    import axi_lite_pkg::*;
#(
    parameter int                       ADDR_WIDTH = 32,
    parameter int                       DATA_WIDTH = 32,
    parameter int                       NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = 32'h4000_0000,
    parameter logic [NUM_REGS-1:0]      RO_MASK    = '0,
    localparam int                      IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx,
    output logic                  ro
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(NUM_REGS * BYTES);

    logic [ADDR_WIDTH-1:0] off;
    logic                  unused_off;

    assign off = addr - BASE_ADDR;
    // Extend by one bit so a window ending at the top of the address space still compares correctly.
    assign hit = (addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    // Byte-lane bits below LSB are dropped: unaligned addresses alias onto their word.
    assign idx = off[LSB +: IDX_W];
    assign ro  = hit && RO_MASK[idx];

    assign unused_off = ^off;
endmodule

// File: rtl/axi_lite_regfile_slave.sv
// axi_lite_regfile_slave: AXI4-Lite endpoint fronting NUM_REGS memory-mapped registers.
// Ports: clk, rst_n, bus (axi_lite_if.slave), regs_o (RW register contents, RO slots 0),
//        hw_ro_i (values returned for registers flagged in RO_MASK).
// Latency: write commits one edge after both AW and W are held; B/R follow after RESP_LATENCY idle cycles.
// Backpressure: one outstanding write and one outstanding read; readys drop until the B/R handshake.
module axi_lite_regfile_slave
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    NUM_REGS     = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h4000_0000,
    parameter logic [NUM_REGS-1:0]   RO_MASK      = '0,
    parameter int                    RESP_LATENCY = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    axi_lite_if.slave                      bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_ro_i
);
    localparam int         BYTES   = DATA_WIDTH / 8;
    localparam int         IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] LAT_CNT = 4'(RESP_LATENCY);

    // Write channel state
    w_state_e              w_state;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [BYTES-1:0]      w_strb_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    axi_resp_e             bresp_q;
    logic [3:0]            w_cnt;

    // Read channel state
    r_state_e              r_state;
    logic                  arready_q;
    logic                  rvalid_q;
    axi_resp_e             rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [3:0]            r_cnt;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic                  wd_hit, wd_ro, rd_hit, rd_ro;
    logic [IDX_W-1:0]      wd_idx, rd_idx;
    logic                  commit;
    axi_resp_e             w_resp, r_resp;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  unused_prot;

    // Write side decodes the held address, so the decode is stable on the commit cycle.
    axi_lite_regfile_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .RO_MASK    (RO_MASK)
    ) u_aw_decode (
        .addr (aw_addr_q),
        .hit  (wd_hit),
        .idx  (wd_idx),
        .ro   (wd_ro)
    );

    // Read side decodes the live araddr: data is captured on the AR handshake edge.
    axi_lite_regfile_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .RO_MASK    (RO_MASK)
    ) u_ar_decode (
        .addr (bus.araddr),
        .hit  (rd_hit),
        .idx  (rd_idx),
        .ro   (rd_ro)
    );

    assign commit = (w_state == W_COLLECT) && aw_held && w_held;
    assign w_resp = !wd_hit ? DECERR : (wd_ro ? SLVERR : OKAY);
    assign r_resp = rd_hit ? OKAY : DECERR;

    always_comb begin
        r_data = '0;
        if (rd_hit) begin
            r_data = rd_ro ? hw_ro_i[rd_idx*DATA_WIDTH +: DATA_WIDTH] : regs_q[rd_idx];
        end
    end

    // Register bank. RO slots are never written, so they stay 0 and read back as 0 on regs_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit && wd_hit && !wd_ro) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_strb_q[b]) begin
                    regs_q[wd_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
                end
            end
        end
    end

    // Write FSM: collect AW and W in any order, commit, optional delay, then hold B until bready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_COLLECT;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            w_cnt     <= '0;
        end else begin
            case (w_state)
                W_COLLECT: begin
                    if (aw_held && w_held) begin
                        bresp_q <= w_resp;
                        if (RESP_LATENCY == 0) begin
                            w_state  <= W_RESP;
                            bvalid_q <= 1'b1;
                        end else begin
                            w_state <= W_DELAY;
                            w_cnt   <= LAT_CNT;
                        end
                    end else begin
                        if (bus.awvalid && awready_q) begin
                            aw_held   <= 1'b1;
                            aw_addr_q <= bus.awaddr;
                            awready_q <= 1'b0;
                        end
                        if (bus.wvalid && wready_q) begin
                            w_held   <= 1'b1;
                            w_data_q <= bus.wdata;
                            w_strb_q <= bus.wstrb;
                            wready_q <= 1'b0;
                        end
                    end
                end
                W_DELAY: begin
                    // w_cnt holds the idle cycles still to elapse, including this one.
                    if (w_cnt == 4'd1) begin
                        w_state  <= W_RESP;
                        bvalid_q <= 1'b1;
                    end else begin
                        w_cnt <= w_cnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bvalid_q  <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= W_COLLECT;
                    end
                end
                default: w_state <= W_COLLECT;
            endcase
        end
    end

    // Read FSM: capture on the AR edge (pre-write value if a write commits the same edge).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (bus.arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        rresp_q   <= r_resp;
                        rdata_q   <= r_data;
                        if (RESP_LATENCY == 0) begin
                            r_state  <= R_RESP;
                            rvalid_q <= 1'b1;
                        end else begin
                            r_state <= R_DELAY;
                            r_cnt   <= LAT_CNT;
                        end
                    end
                end
                R_DELAY: begin
                    if (r_cnt == 4'd1) begin
                        r_state  <= R_RESP;
                        rvalid_q <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (bus.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_o
        assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    assign unused_prot = ^{bus.awprot, bus.arprot};
endmodule
